rs485_cmd_receiver: RTL
=======================

Name: rs485_cmd_receiver

Overview:
- Upstream stage of the RS485 slave transmit path. Deserializes 11-bit RS485 frames from the bus master, filters them by slave address, and assembles CMD_BYTES data bytes into one command word.
- Presents the command word on a valid/ready handshake to the transmit side.
- Frame format, idle high: start 0, data[0..7] LSB first, flag bit (1 = address frame, 0 = data frame), stop 1. This is the same frame format the transmit side emits.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per bit; even, minimum 4.
- SLAVE_ADDR, 8'h01: address accepted in address frames.
- CMD_BYTES, 2: data frames per command; range 1..4.
- TIMEOUT_BITS, 32: maximum idle bit-times between frames while collecting.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- rx  in  1  asynchronous serial line from transceiver, idle high
- rx_en  in  1  receive enable; low while this node drives the bus (half-duplex)
- cmd_data  out  8*CMD_BYTES  assembled command; first byte in [7:0]
- cmd_valid  out  1  command available
- cmd_ready  in  1  consumer accepts command
- addr_match  out  1  1-cycle pulse: matching address frame received
- frame_err  out  1  1-cycle pulse: stop bit sampled 0
- timeout  out  1  1-cycle pulse: inter-frame timeout while collecting
- overrun  out  1  1-cycle pulse: complete frame discarded while holding a command
- busy  out  1  high while the frame FSM is not in HUNT

Behaviour:
- Reset: all outputs 0, cmd_data 0, synchronizer flops 1, bit FSM IDLE, frame FSM HUNT, counters 0.
- Input path: rx passes through a 2-flop synchronizer. All sampling uses the synchronized value.

Bit FSM (IDLE, START, DATA, FLAG, STOP, WAIT_HIGH):
- IDLE: a falling edge of synchronized rx goes to START and clears the cycle counter.
- START: sample at CLKS_PER_BIT/2-1. If rx is high, this is a false start: return to IDLE with no pulse. If low, go to DATA.
- DATA: sample each subsequent bit every CLKS_PER_BIT cycles, shifting LSB first.
- FLAG: capture the 9th bit as the flag.
- STOP: if rx is 1, issue frame_done for 1 cycle with the byte and flag. If rx is 0, pulse frame_err, discard the frame, and go to WAIT_HIGH.
- WAIT_HIGH: return to IDLE once synchronized rx is 1.
- rx_en low: force IDLE in the same cycle and silently abort any partial frame. Frame FSM state is kept; the timeout counter is frozen.

Frame FSM (HUNT, COLLECT, HOLD). All responses occur on the cycle after frame_done:
- HUNT, address frame == SLAVE_ADDR: pulse addr_match, clear byte index, go to COLLECT.
- HUNT, data frame or non-matching address: ignored.
- COLLECT, data frame: store byte at cmd_data[8*idx +: 8] and increment idx. When idx reaches CMD_BYTES, go to HOLD with cmd_valid=1.
- COLLECT, matching address frame: pulse addr_match and restart idx at 0.
- COLLECT, non-matching address frame: go to HUNT.
- COLLECT, frame_err: go to HUNT.
- COLLECT, timeout: no start bit within TIMEOUT_BITS*CLKS_PER_BIT cycles after the last stop sample. Pulse timeout and go to HUNT.
- HOLD: cmd_valid and cmd_data remain stable until the cycle cmd_valid&cmd_ready is high. Then cmd_valid drops and the FSM returns to HUNT.
- HOLD, any completed frame (frame_done or frame_err): pulse overrun and discard the frame. No addr_match is issued.
- Simultaneous handshake and frame_done in HOLD: handshake wins, overrun pulses, and the frame is discarded.
- Latency: cmd_valid rises 1 cycle after the last data byte's stop-bit sample.
- Width rules: idx is clog2(CMD_BYTES+1) bits. The cycle counter is sized for TIMEOUT_BITS*CLKS_PER_BIT; no wrap is permitted.

Decomposition:
- rs485_pkg: frame length constant 11, FLAG_ADDR=1 / FLAG_DATA=0, bit-FSM and frame-FSM state encodings.
- Sub-module rs485_bit_rx: synchronizer plus bit FSM. Outputs byte[7:0], flag, frame_done, frame_err; input rx_en.
- rs485_cmd_receiver: instantiates rs485_bit_rx and implements the frame FSM, timeout counter, and output registers.

Test Plan (CLKS_PER_BIT=16, defaults otherwise):
1. Address frame 0x01/flag 1, then data 0x34 and 0x12/flag 0, cmd_ready=1 -> one addr_match pulse; cmd_valid for 1 cycle with cmd_data=16'h1234; busy returns to 0.
2. Address 0x05, then data 0x34, 0x12 -> no addr_match, no cmd_valid, cmd_data stays 0.
3. Address 0x01, data 0x34, then data frame with stop=0 -> frame_err pulse, no cmd_valid, FSM in HUNT. A following correct sequence with data 0xAA, 0x55 yields cmd_data=16'h55AA.
4. rx low for 4 cycles only -> no frame_done, no pulses. rx toggled while rx_en=0 -> nothing received.
5. Complete command held with cmd_ready=0, then another 0x01 address frame -> overrun pulse, cmd_data unchanged at 16'h1234. After cmd_ready=1, one handshake completes.
6. Address 0x01, data 0x34, then 32*16 idle cycles -> timeout pulse, busy=0. Separately, reset asserted mid-DATA -> all outputs 0 immediately; the next full sequence works.

Source files
------------

// File: rtl/rs485_pkg.sv
// Shared constants and state encodings for the RS485 command receiver.
// Frame: start, 8 data bits LSB first, flag (1 = address), stop.
package rs485_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;

  localparam logic FLAG_ADDR = 1'b1;
  localparam logic FLAG_DATA = 1'b0;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_FLAG,
    B_STOP,
    B_WAIT_HIGH
  } bit_state_e;

  typedef enum logic [1:0] {
    F_HUNT,
    F_COLLECT,
    F_HOLD
  } frame_state_e;

endpackage

// File: rtl/rs485_bit_rx.sv
// Synchronizer plus bit FSM: turns the rx line into byte/flag frames.
// Ports: clk, reset, rx, rx_en in; o_byte, o_flag, o_frame_done, o_frame_err, o_idle out.
module rs485_bit_rx
  import rs485_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_en,
  output logic [7:0] o_byte,
  output logic       o_flag,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic       o_idle
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_prev;
  bit_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          r_flag;
  logic          r_done;
  logic          r_err;

  logic w_fall;
  logic w_tick;

  assign w_fall = r_prev & ~r_s2;
  assign w_tick = (r_cnt == LAST);

  assign o_byte       = r_sh;
  assign o_flag       = r_flag;
  assign o_frame_done = r_done;
  assign o_frame_err  = r_err;
  assign o_idle       = (r_state == B_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= B_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_flag  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_s1   <= rx;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (!rx_en) begin
        r_state <= B_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          B_IDLE: begin
            if (w_fall) begin
              r_state <= B_START;
              r_cnt   <= '0;
            end
          end
          B_START: begin
            if (r_cnt == HALF) begin
              r_cnt   <= '0;
              r_bit   <= '0;
              r_state <= r_s2 ? B_IDLE : B_DATA;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          B_DATA: begin
            if (w_tick) begin
              r_cnt <= '0;
              r_sh  <= {r_s2, r_sh[7:1]};
              if (r_bit == LAST_BIT) begin
                r_state <= B_FLAG;
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          B_FLAG: begin
            if (w_tick) begin
              r_cnt   <= '0;
              r_flag  <= r_s2;
              r_state <= B_STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          B_STOP: begin
            if (w_tick) begin
              r_cnt <= '0;
              if (r_s2) begin
                r_done  <= 1'b1;
                r_state <= B_IDLE;
              end else begin
                r_err   <= 1'b1;
                r_state <= B_WAIT_HIGH;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          B_WAIT_HIGH: begin
            if (r_s2) begin
              r_state <= B_IDLE;
            end
          end
          default: r_state <= B_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/rs485_cmd_receiver.sv
// Address-filtered RS485 command receiver with valid/ready output.
// Ports: clk, reset, rx, rx_en, cmd_ready in; cmd_data, cmd_valid, pulses, busy out.
module rs485_cmd_receiver
  import rs485_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] SLAVE_ADDR   = 8'h01,
  parameter int         CMD_BYTES    = 2,
  parameter int         TIMEOUT_BITS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  input  logic                   rx_en,
  output logic [8*CMD_BYTES-1:0] cmd_data,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   addr_match,
  output logic                   frame_err,
  output logic                   timeout,
  output logic                   overrun,
  output logic                   busy
);

  localparam int IDXW  = $clog2(CMD_BYTES + 1);
  localparam int LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW    = $clog2(LIMIT + 1);

  logic [7:0] w_byte;
  logic       w_flag;
  logic       w_done;
  logic       w_err;
  logic       w_idle;
  logic       w_addr_hit;
  logic       w_data_fr;

  frame_state_e           r_state;
  logic [IDXW-1:0]        r_idx;
  logic [TW-1:0]          r_tcnt;
  logic [8*CMD_BYTES-1:0] r_data;
  logic                   r_valid;
  logic                   r_am;
  logic                   r_ferr;
  logic                   r_to;
  logic                   r_ov;

  rs485_bit_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_rx (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_en       (rx_en),
    .o_byte      (w_byte),
    .o_flag      (w_flag),
    .o_frame_done(w_done),
    .o_frame_err (w_err),
    .o_idle      (w_idle)
  );

  assign w_addr_hit = w_done && (w_flag == FLAG_ADDR)
                      && (w_byte == SLAVE_ADDR);
  assign w_data_fr  = w_done && (w_flag == FLAG_DATA);

  assign cmd_data   = r_data;
  assign cmd_valid  = r_valid;
  assign addr_match = r_am;
  assign frame_err  = r_ferr;
  assign timeout    = r_to;
  assign overrun    = r_ov;
  assign busy       = (r_state != F_HUNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= F_HUNT;
      r_idx   <= '0;
      r_tcnt  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_am    <= 1'b0;
      r_ferr  <= 1'b0;
      r_to    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_am   <= 1'b0;
      r_to   <= 1'b0;
      r_ov   <= 1'b0;
      r_ferr <= w_err;
      case (r_state)
        F_HUNT: begin
          r_tcnt <= '0;
          if (w_addr_hit) begin
            r_am    <= 1'b1;
            r_idx   <= '0;
            r_state <= F_COLLECT;
          end
        end
        F_COLLECT: begin
          if (w_data_fr) begin
            r_tcnt <= '0;
            for (int i = 0; i < CMD_BYTES; i++) begin
              if (r_idx == IDXW'(i)) begin
                r_data[8*i +: 8] <= w_byte;
              end
            end
            r_idx <= r_idx + 1'b1;
            if (r_idx == IDXW'(CMD_BYTES - 1)) begin
              r_valid <= 1'b1;
              r_state <= F_HOLD;
            end
          end else if (w_addr_hit) begin
            r_am   <= 1'b1;
            r_idx  <= '0;
            r_tcnt <= '0;
          end else if (w_done || w_err) begin
            r_state <= F_HUNT;
          end else if (!w_idle) begin
            // a start bit arrived: the inter-frame gap is over
            r_tcnt <= '0;
          end else if (rx_en) begin
            if (r_tcnt == TW'(LIMIT - 1)) begin
              r_to    <= 1'b1;
              r_state <= F_HUNT;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        F_HOLD: begin
          if (w_done || w_err) begin
            r_ov <= 1'b1;
          end
          if (r_valid && cmd_ready) begin
            r_valid <= 1'b0;
            r_state <= F_HUNT;
          end
        end
        default: r_state <= F_HUNT;
      endcase
    end
  end

endmodule
